// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bus bundle for the two-requester data-memory arbiter:
//                two request/response channels plus the memory-side port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if;
   // requester 0 (CPU load/store path)
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_addr;
   logic [31:0] req0_wdata;
   logic [3:0]  req0_we;
   logic        rsp0_valid;
   logic [31:0] rsp0_rdata;
   logic        rsp0_err;
   // requester 1 (DMA / debug master)
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_addr;
   logic [31:0] req1_wdata;
   logic [3:0]  req1_we;
   logic        rsp1_valid;
   logic [31:0] rsp1_rdata;
   logic        rsp1_err;
   // data-memory port
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;

   // arbiter side
   modport slave (
      input  req0_valid, req0_addr, req0_wdata, req0_we,
      input  req1_valid, req1_addr, req1_wdata, req1_we,
      input  mem_rdata,
      output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
      output mem_addr, mem_wdata, mem_we
   );

   // requesters + memory side
   modport master (
      output req0_valid, req0_addr, req0_wdata, req0_we,
      output req1_valid, req1_addr, req1_wdata, req1_we,
      output mem_rdata,
      input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
      input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
      input  mem_addr, mem_wdata, mem_we
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one data-memory port between two requesters.
//                Accept -> one-cycle memory issue -> one-cycle response pulse.
//                Out-of-range word addresses are blocked and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int unsigned MEM_SIZE   = 128,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  wire logic       clk,
   input  wire logic       rst,
   dmem_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   // 33-bit compare so an address near 0xFFFFFFFF cannot wrap into range
   localparam logic [32:0] C_LIMIT = 33'(MEM_SIZE);

   state_t      state_q;
   logic        last_grant_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  we_q;
   logic        err_q;
   logic        id_q;
   logic [31:0] rdata_q;
   logic        rsp_err_q;
   logic        rsp0_valid_q;
   logic        rsp1_valid_q;
   logic [3:0]  mem_we_q;

   logic        can_accept;
   logic        grant1;
   logic        ready0;
   logic        ready1;
   logic        handshake;
   logic [31:0] addr_d;
   logic [31:0] wdata_d;
   logic [3:0]  we_d;
   logic        err_d;

   // Grant selection and muxing of the winning request into the capture path
   always_comb begin
      can_accept = (state_q != S_ISSUE) && !rst;
      // requester 1 wins when alone, or on a tie when round-robin says it is its turn
      grant1     = bus.req1_valid &&
                   (!bus.req0_valid || ((FIXED_PRIO == 0) && !last_grant_q));
      ready0     = can_accept && bus.req0_valid && !grant1;
      ready1     = can_accept && grant1;
      handshake  = ready0 || ready1;
      addr_d     = grant1 ? bus.req1_addr  : bus.req0_addr;
      wdata_d    = grant1 ? bus.req1_wdata : bus.req0_wdata;
      we_d       = grant1 ? bus.req1_we    : bus.req0_we;
      err_d      = (({1'b0, addr_d[31:2], 2'b00} + 33'd3) >= C_LIMIT);
   end

   // Sequencer FSM: capture on accept, issue for one cycle, then pulse the response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         we_q         <= 4'd0;
         err_q        <= 1'b0;
         id_q         <= 1'b0;
         rdata_q      <= 32'd0;
         rsp_err_q    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         mem_we_q     <= 4'd0;
      end else begin
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         mem_we_q     <= 4'd0;
         case (state_q)
            S_IDLE, S_RESP: begin
               if (handshake) begin
                  addr_q       <= addr_d;
                  wdata_q      <= wdata_d;
                  we_q         <= we_d;
                  err_q        <= err_d;
                  id_q         <= grant1;
                  last_grant_q <= grant1;
                  // blocked accesses never reach the memory write strobes
                  mem_we_q     <= err_d ? 4'd0 : we_d;
                  state_q      <= S_ISSUE;
               end else begin
                  state_q      <= S_IDLE;
               end
            end
            S_ISSUE: begin
               // memory reads combinationally, so a write returns the pre-write word
               rdata_q      <= err_q ? 32'd0 : bus.mem_rdata;
               rsp_err_q    <= err_q;
               rsp0_valid_q <= !id_q;
               rsp1_valid_q <= id_q;
               state_q      <= S_RESP;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.rsp0_valid = rsp0_valid_q;
   assign bus.rsp1_valid = rsp1_valid_q;
   assign bus.rsp0_rdata = rdata_q;
   assign bus.rsp1_rdata = rdata_q;
   assign bus.rsp0_err   = rsp_err_q;
   assign bus.rsp1_err   = rsp_err_q;
   assign bus.mem_addr   = {addr_q[31:2], 2'b00};
   assign bus.mem_wdata  = wdata_q;
   assign bus.mem_we     = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Directed self-checking bench for dmem_arbiter, with a
//                byte-array memory model behind the arbiter's memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if ifc ();
   dmem_arbiter_if ifc2 ();

   dmem_arbiter #(.MEM_SIZE(128), .FIXED_PRIO(0)) u_dut (
      .clk (clk), .rst (rst), .bus (ifc.slave));

   dmem_arbiter #(.MEM_SIZE(128), .FIXED_PRIO(1)) u_dut_fp (
      .clk (clk), .rst (rst), .bus (ifc2.slave));

   // byte-addressable memory with combinational read and clocked byte-lane write
   logic [7:0] tmem [0:127];
   logic [6:0] mi;
   assign mi = ifc.mem_addr[6:0];
   assign ifc.mem_rdata = {tmem[{mi[6:2], 2'd3}], tmem[{mi[6:2], 2'd2}],
                           tmem[{mi[6:2], 2'd1}], tmem[{mi[6:2], 2'd0}]};
   assign ifc2.mem_rdata = 32'h0;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 128; i++) tmem[i] <= 8'h00;
      end else begin
         for (int k = 0; k < 4; k++)
            if (ifc.mem_we[k]) tmem[{mi[6:2], 2'(k)}] <= ifc.mem_wdata[8*k +: 8];
      end
   end

   // observed result of one transaction
   typedef struct packed {
      logic        acc;    // accepted within the bound
      logic [3:0]  we;     // mem_we during ISSUE
      logic [31:0] addr;   // mem_addr during ISSUE
      logic        early;  // any rsp_valid during ISSUE
      logic        own;    // owner rsp_valid in RESP
      logic        oth;    // other rsp_valid in RESP
      logic [31:0] rd;     // owner rdata in RESP
      logic        err;    // owner err in RESP
   } xres_t;

   task automatic drive(input int n, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] we);
      if (n == 0) begin
         ifc.req0_valid = v; ifc.req0_addr = a; ifc.req0_wdata = wd; ifc.req0_we = we;
      end else begin
         ifc.req1_valid = v; ifc.req1_addr = a; ifc.req1_wdata = wd; ifc.req1_we = we;
      end
   endtask

   // run one request on port n and record what the DUT does in ISSUE and RESP
   task automatic xact(input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] we, output xres_t o);
      int   k;
      logic rdy;
      o = '0;
      @(negedge clk);
      drive(n, 1'b1, a, wd, we);
      #1;
      rdy = (n == 0) ? ifc.req0_ready : ifc.req1_ready;
      k = 0;
      while (!rdy && k < 20) begin
         @(negedge clk); #1;
         rdy = (n == 0) ? ifc.req0_ready : ifc.req1_ready;
         k++;
      end
      o.acc = rdy;
      @(negedge clk);
      drive(n, 1'b0, 32'h0, 32'h0, 4'h0);
      o.we    = ifc.mem_we;
      o.addr  = ifc.mem_addr;
      o.early = ifc.rsp0_valid | ifc.rsp1_valid;
      @(negedge clk);
      o.own = (n == 0) ? ifc.rsp0_valid : ifc.rsp1_valid;
      o.oth = (n == 0) ? ifc.rsp1_valid : ifc.rsp0_valid;
      o.rd  = (n == 0) ? ifc.rsp0_rdata : ifc.rsp1_rdata;
      o.err = (n == 0) ? ifc.rsp0_err   : ifc.rsp1_err;
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      @(negedge clk); rst = 1'b0;
   endtask

   task automatic test_reset();
      drive(0, 1'b1, 32'h10, 32'h1, 4'hF);
      drive(1, 1'b1, 32'h20, 32'h2, 4'hF);
      @(negedge clk); @(negedge clk);
      nvec++;
      if ({ifc.req0_ready, ifc.req1_ready, ifc.rsp0_valid, ifc.rsp1_valid} !== 4'b0000) begin
         nerr++; $display("FAIL reset_ctrl: rdy0/rdy1/rsp0/rsp1=%b required 0000",
                          {ifc.req0_ready, ifc.req1_ready, ifc.rsp0_valid, ifc.rsp1_valid});
      end
      nvec++;
      if ({ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.rsp0_rdata, ifc.rsp0_err} !== 101'd0) begin
         nerr++; $display("FAIL reset_data: we=%h addr=%h wdata=%h rdata=%h err=%b required all 0",
                          ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.rsp0_rdata, ifc.rsp0_err);
      end
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b0; mem_clr = 1'b0;
   endtask

   task automatic test_write_read();
      xres_t o, e;
      xact(0, 32'h10, 32'hDEADBEEF, 4'hF, o);
      e = '{1'b1, 4'hF, 32'h10, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL wr_0x10: got %h required %h", o, e); end
      xact(0, 32'h10, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'h10, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL rd_0x10: got %h required %h", o, e); end
   endtask

   task automatic test_byte_lane();
      xres_t o, e;
      xact(0, 32'h20, 32'h11223344, 4'hF, o);
      e = '{1'b1, 4'hF, 32'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL bl_init: got %h required %h", o, e); end
      xact(1, 32'h20, 32'hAABBCCDD, 4'b0101, o);
      e = '{1'b1, 4'b0101, 32'h20, 1'b0, 1'b1, 1'b0, 32'h11223344, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL bl_write1: got %h required %h", o, e); end
      xact(0, 32'h20, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'h20, 1'b0, 1'b1, 1'b0, 32'h11BB33DD, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL bl_read: got %h required %h", o, e); end
   endtask

   task automatic test_out_of_range();
      xres_t o, e;
      xact(0, 32'h7C, 32'h12345678, 4'hF, o);
      e = '{1'b1, 4'hF, 32'h7C, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL oor_wr7c: got %h required %h", o, e); end
      xact(0, 32'h80, 32'h55555555, 4'hF, o);
      e = '{1'b1, 4'h0, 32'h80, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
      nvec++; if (o !== e) begin nerr++; $display("FAIL oor_wr80: got %h required %h", o, e); end
      xact(0, 32'h7C, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'h7C, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL oor_rd7c: got %h required %h", o, e); end
      xact(1, 32'h7F, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'h7C, 1'b0, 1'b1, 1'b0, 32'h12345678, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL oor_rd7f: got %h required %h", o, e); end
      xact(1, 32'hFFFFFFFC, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1};
      nvec++; if (o !== e) begin nerr++; $display("FAIL oor_rdwrap: got %h required %h", o, e); end
   endtask

   task automatic test_back_to_back();
      int   g;
      int   gid [4];
      int   hs  [0:15];
      logic e0, e1;
      for (int i = 0; i < 16; i++) hs[i] = -1;
      for (int i = 0; i < 4; i++) gid[i] = -1;
      g = 0;
      apply_reset();
      drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
      drive(1, 1'b1, 32'h20, 32'h0, 4'h0);
      for (int t = 0; t < 12; t++) begin
         #1;
         nvec++;
         if (ifc.req0_ready && ifc.req1_ready) begin
            nerr++; $display("FAIL b2b_tworeadies: cycle %0d both ready, required at most one", t);
         end
         if (ifc.req0_ready || ifc.req1_ready) begin
            hs[t] = ifc.req1_ready ? 1 : 0;
            if (g < 4) gid[g] = hs[t];
            g++;
         end
         e0 = (t >= 2) && (hs[t-2] == 0);
         e1 = (t >= 2) && (hs[t-2] == 1);
         nvec++;
         if ({ifc.rsp0_valid, ifc.rsp1_valid} !== {e0, e1}) begin
            nerr++; $display("FAIL b2b_rsp: cycle %0d rsp0/rsp1=%b%b required %b%b",
                             t, ifc.rsp0_valid, ifc.rsp1_valid, e0, e1);
         end
         if (ifc.rsp0_valid) begin
            nvec++;
            if (ifc.rsp0_rdata !== 32'hDEADBEEF) begin
               nerr++; $display("FAIL b2b_rd0: rdata=%h required deadbeef", ifc.rsp0_rdata);
            end
         end
         if (ifc.rsp1_valid) begin
            nvec++;
            if (ifc.rsp1_rdata !== 32'h11BB33DD) begin
               nerr++; $display("FAIL b2b_rd1: rdata=%h required 11bb33dd", ifc.rsp1_rdata);
            end
         end
         @(negedge clk);
         if (g >= 4) begin
            drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
            drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
      nvec++;
      if (g != 4 || gid[0] != 0 || gid[1] != 1 || gid[2] != 0 || gid[3] != 1) begin
         nerr++; $display("FAIL b2b_order: %0d grants %0d,%0d,%0d,%0d required 4 grants 0,1,0,1",
                          g, gid[0], gid[1], gid[2], gid[3]);
      end
   endtask

   task automatic test_fixed_prio();
      int n0, n1, k;
      n0 = 0; n1 = 0;
      @(negedge clk);
      ifc2.req0_valid = 1'b1; ifc2.req0_addr = 32'h4; ifc2.req0_wdata = 32'h0; ifc2.req0_we = 4'h0;
      ifc2.req1_valid = 1'b1; ifc2.req1_addr = 32'h8; ifc2.req1_wdata = 32'h0; ifc2.req1_we = 4'h0;
      for (int t = 0; t < 8; t++) begin
         #1;
         if (ifc2.req0_ready) n0++;
         if (ifc2.req1_ready) n1++;
         @(negedge clk);
      end
      nvec++;
      if (n0 != 4 || n1 != 0) begin
         nerr++; $display("FAIL fp_tie: grants r0=%0d r1=%0d required r0=4 r1=0", n0, n1);
      end
      ifc2.req0_valid = 1'b0;
      k = 0;
      #1;
      while (!ifc2.req1_ready && k < 4) begin @(negedge clk); #1; k++; end
      nvec++;
      if (ifc2.req1_ready !== 1'b1) begin
         nerr++; $display("FAIL fp_release: req1_ready=%b required 1 after req0 drops", ifc2.req1_ready);
      end
      @(negedge clk);
      ifc2.req1_valid = 1'b0;
   endtask

   task automatic test_reset_mid_xact();
      xres_t o, e;
      int    k;
      logic  seen;
      xact(0, 32'h30, 32'hCAFEF00D, 4'hF, o);
      e = '{1'b1, 4'hF, 32'h30, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL rst_prep: got %h required %h", o, e); end
      // start an overwrite and reset it while it is in ISSUE
      @(negedge clk);
      drive(0, 1'b1, 32'h30, 32'h99999999, 4'hF);
      k = 0; #1;
      while (!ifc.req0_ready && k < 20) begin @(negedge clk); #1; k++; end
      @(negedge clk);
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
      nvec++;
      if (ifc.mem_we !== 4'hF) begin
         nerr++; $display("FAIL rst_issue_we: mem_we=%h required f before reset", ifc.mem_we);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if (ifc.mem_we !== 4'h0) begin
         nerr++; $display("FAIL rst_async_we: mem_we=%h required 0 right after reset", ifc.mem_we);
      end
      @(negedge clk); rst = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 4; t++) begin
         #1; seen = seen | ifc.rsp0_valid | ifc.rsp1_valid;
         @(negedge clk);
      end
      nvec++;
      if (seen !== 1'b0) begin
         nerr++; $display("FAIL rst_stray_rsp: rsp_valid seen=%b required 0", seen);
      end
      xact(0, 32'h30, 32'h0, 4'h0, o);
      e = '{1'b1, 4'h0, 32'h30, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0};
      nvec++; if (o !== e) begin nerr++; $display("FAIL rst_lost_write: got %h required %h", o, e); end
      // reset asserted while the response pulse is up
      @(negedge clk);
      drive(1, 1'b1, 32'h30, 32'h0, 4'h0);
      k = 0; #1;
      while (!ifc.req1_ready && k < 20) begin @(negedge clk); #1; k++; end
      @(negedge clk);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      nvec++;
      if (ifc.rsp1_valid !== 1'b1) begin
         nerr++; $display("FAIL rst_resp_pre: rsp1_valid=%b required 1", ifc.rsp1_valid);
      end
      rst = 1'b1;
      #1;
      nvec++;
      if (ifc.rsp1_valid !== 1'b0) begin
         nerr++; $display("FAIL rst_resp_drop: rsp1_valid=%b required 0 right after reset", ifc.rsp1_valid);
      end
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
      ifc2.req0_valid = 1'b0; ifc2.req0_addr = 32'h0; ifc2.req0_wdata = 32'h0; ifc2.req0_we = 4'h0;
      ifc2.req1_valid = 1'b0; ifc2.req1_addr = 32'h0; ifc2.req1_wdata = 32'h0; ifc2.req1_we = 4'h0;
      test_reset();
      test_write_read();
      test_byte_lane();
      test_out_of_range();
      test_back_to_back();
      test_fixed_prio();
      test_reset_mid_xact();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the byte-addressable data memory. It shares the single data-memory port between the CPU load/store path (requester 0) and a DMA/debug master (requester 1). Each accepted request is registered, issued to memory for exactly one cycle, and answered with a one-cycle response pulse. Out-of-range accesses are blocked and flagged.

## Interface
- MEM_SIZE, 128: memory size in bytes; word-aligned address valid iff `(addr & ~3) + 3 < MEM_SIZE`
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (`valid && ready` = handshake)
- req0_addr / req1_addr  in  32  byte address; bits [1:0] ignored (word-aligned)
- req0_wdata / req1_wdata  in  32  write data
- req0_we / req1_we  in  4  byte-lane write enables; 0 = read
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  32  read word; valid with rsp_valid
- rsp0_err / rsp1_err  out  1  address out of range; valid with rsp_valid
- mem_addr  out  32  to memory daddr
- mem_wdata  out  32  to memory dwdata
- mem_we  out  4  to memory we
- mem_rdata  in  32  from memory drdata (combinational read)

## Operation
- FSM states:
  - IDLE: accept.
  - ISSUE: drive memory.
  - RESP: emit response; may accept.
- Transitions:
  - IDLE/RESP → ISSUE on handshake.
  - IDLE/RESP → IDLE otherwise.
  - ISSUE → RESP unconditionally.
- Grant (combinational) in IDLE/RESP:
  - Only one valid: that requester wins.
  - Both valid, round-robin: the requester not in `last_grant` wins.
  - Both valid, FIXED_PRIO=1: requester 0 wins.
- `reqN_ready` = (state ≠ ISSUE) && granted N && !rst. At most one ready is high per cycle. Ready is 0 in ISSUE.
- On handshake, register addr, wdata, we, requester id and `err` (range check), and update `last_grant` to the winner.
- ISSUE:
  - `mem_addr` = registered addr with [1:0] forced to 0.
  - `mem_wdata` = registered wdata.
  - `mem_we` = registered we if !err, else 4'b0000.
  - At the end of ISSUE, capture `mem_rdata` into the response register. If err, capture 0 instead.
- `mem_we` = 0 in all states other than ISSUE. `mem_addr`/`mem_wdata` hold their last registered values.
- RESP: `rspN_valid`=1 only for the requester that owned the transaction. `rdata`/`err` hold until the next capture.
- Writes also return `rdata`: the pre-write word, because memory reads combinationally during the write cycle.
- Requesters must hold valid/addr/wdata/we stable until ready. The arbiter does not check this.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=1 (requester 0 wins first tie).
  - Registered addr/wdata/we/err/id = 0.
  - All ready/rsp_valid/rsp_err = 0, rsp_rdata = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Latency: handshake in cycle C → ISSUE in C+1 (write commits at end of C+1) → `rsp_valid` in C+2.
- Throughput: one transaction per 2 cycles sustained, since RESP overlaps the next accept.
- Back-to-back with both requesters valid under round-robin: grants alternate 0,1,0,1…
- Reset mid-ISSUE: `mem_we` drops immediately (asynchronous), the write is lost, and no response is emitted.
- Reset in RESP: `rsp_valid` drops immediately.
- Address boundary with MEM_SIZE=128:
  - addr 124..127 valid.
  - addr 128 err.
  - addr 0xFFFFFFFC err; range check must not wrap.

## Test plan
- Single write then read, req0:
  - Stimulus: write addr 0x10, wdata 0xDEADBEEF, we 4'hF; then read 0x10.
  - Response: write responds 2 cycles after accept with err=0; read returns 0xDEADBEEF.
- Byte-lane write:
  - Stimulus: word 0x11223344 at 0x20; req1 writes 0xAABBCCDD with we 4'b0101; then read 0x20.
  - Response: read returns 0x11BB33DD.
- Contention, round-robin:
  - Stimulus: both valid continuously for 4 transactions from reset.
  - Response: grant order 0,1,0,1; each rsp pulses only to its owner; no cycle has two readies.
- FIXED_PRIO=1:
  - Stimulus: both valid continuously.
  - Response: requester 1 is never ready until req0_valid drops.
- Out of range:
  - Stimulus: write 0x80 with we 4'hF, then read 0x7C.
  - Response: write gets err=1 and `mem_we` stays 0; read of 0x7C gets err=0 and unchanged data; read of 0xFFFFFFFC gets err=1, rdata 0.
- Async reset asserted during ISSUE of a write to 0x30:
  - Response: `mem_we` goes 0 within the same cycle; after release, reading 0x30 returns the old data and no stray rsp_valid appears.
